// File: rtl/controle_velocidade_pkg.sv
// Shared constants, FSM state type and counter sizing helper for the
// speed-level controller and its button debouncers.
package vel_pkg;

    // Speed codes at the two ends of the range.
    localparam logic [1:0] VEL_PARADO = 2'b00;
    localparam logic [1:0] VEL_MAX    = 2'b11;

    // IDLE accepts up/down requests; HOLD drops them while the rate limit runs.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } estado_t;

    // Width of a counter that must hold values 0 .. n-1 (never less than 1 bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/controle_velocidade_debounce_botao.sv
// One push-button channel: two-flop synchroniser, counting debouncer and a
// one-cycle request on each debounced rising edge (releases give nothing).
module debounce_botao
    import vel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic req
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          deb_reg;
    logic          deb_prev_reg;
    logic [CW-1:0] cnt_reg;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
        end
    end

    // Flip the debounced state only after the synchronised input has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_reg      <= 1'b0;
            deb_prev_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            deb_prev_reg <= deb_reg;
            if (sync2_reg != deb_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    deb_reg <= ~deb_reg;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign req = deb_reg & ~deb_prev_reg;

endmodule

// File: rtl/controle_velocidade.sv
// Speed-level controller: debounced up/down/stop presses step a saturating
// 2-bit level, a hold window rate-limits changes, stop overrides everything.
module controle_velocidade
    import vel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STEP_HOLD       = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_stop,
    output logic A,
    output logic B,
    output logic changing,
    output logic at_limit
);

    localparam int HW = cnt_width(STEP_HOLD);
    localparam logic [HW-1:0] HOLD_INIT = HW'(STEP_HOLD - 1);

    // Channel order: 0 = up, 1 = down, 2 = stop.
    logic [2:0] btn;
    logic [2:0] req;
    logic       up_req;
    logic       down_req;
    logic       stop_req;

    assign btn      = {btn_stop, btn_down, btn_up};
    assign up_req   = req[0];
    assign down_req = req[1];
    assign stop_req = req[2];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_botao
            debounce_botao #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset_n(reset_n),
                .btn    (btn[gi]),
                .req    (req[gi])
            );
        end
    endgenerate

    estado_t       state_reg;
    estado_t       state_next;
    logic [HW-1:0] hold_reg;
    logic [HW-1:0] hold_next;
    logic [1:0]    level_reg;
    logic [1:0]    level_next;
    logic          changing_reg;
    logic          changing_next;
    logic          at_limit_reg;

    // Next level, hold window and change pulse; stop wins over everything.
    always_comb begin
        state_next    = state_reg;
        hold_next     = hold_reg;
        level_next    = level_reg;
        changing_next = 1'b0;

        if (state_reg == HOLD) begin
            if (hold_reg == '0) begin
                state_next = IDLE;
            end else begin
                hold_next = hold_reg - HW'(1);
            end
        end

        if (stop_req) begin
            // Stopping an already stopped controller is a no-op.
            if (level_reg != VEL_PARADO) begin
                level_next    = VEL_PARADO;
                changing_next = 1'b1;
                state_next    = HOLD;
                hold_next     = HOLD_INIT;
            end
        end else if (state_reg == IDLE) begin
            // Simultaneous up and down cancel each other out.
            if (up_req && !down_req && level_reg != VEL_MAX) begin
                level_next    = level_reg + 2'd1;
                changing_next = 1'b1;
                state_next    = HOLD;
                hold_next     = HOLD_INIT;
            end else if (down_req && !up_req && level_reg != VEL_PARADO) begin
                level_next    = level_reg - 2'd1;
                changing_next = 1'b1;
                state_next    = HOLD;
                hold_next     = HOLD_INIT;
            end
        end
    end

    // Register FSM, hold counter, level and the flags derived from the new level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            hold_reg     <= '0;
            level_reg    <= VEL_PARADO;
            changing_reg <= 1'b0;
            at_limit_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            hold_reg     <= hold_next;
            level_reg    <= level_next;
            changing_reg <= changing_next;
            at_limit_reg <= (level_next == VEL_PARADO) || (level_next == VEL_MAX);
        end
    end

    assign A        = level_reg[1];
    assign B        = level_reg[0];
    assign changing = changing_reg;
    assign at_limit = at_limit_reg;

endmodule
